// File: rtl/rtx_pixel_scheduler_pkg.sv
// rtx_types: default frame geometry, framebuffer address width and the
// packed pixel coordinate bundle shared by the scheduler, its FIFO and bus.
package rtx_types;
  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;
  localparam int H_W        = 11;
  localparam int V_W        = 10;
  localparam int FB_ADDR_W  = $clog2(DEF_WIDTH * DEF_HEIGHT);

  typedef struct packed {
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
  } coord_t;

  function automatic int fb_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction
endpackage

// File: rtl/rtx_pixel_scheduler_if.sv
// Scheduler bus: ray issue (new_ray/pixel_h_out/pixel_v_out), tracer
// results (ray_done/rtx_pixel) and framebuffer write port (fb_*).
interface rtx_pixel_scheduler_if
  import rtx_types::*;
#(
  parameter int AW = FB_ADDR_W
);
  logic           new_ray;
  logic [H_W-1:0] pixel_h_out;
  logic [V_W-1:0] pixel_v_out;
  logic           ray_done;
  logic [15:0]    rtx_pixel;
  logic           fb_we;
  logic [AW-1:0]  fb_addr;
  logic [H_W-1:0] fb_h;
  logic [V_W-1:0] fb_v;
  logic [15:0]    fb_data;

  modport master (
    output new_ray, pixel_h_out, pixel_v_out,
    output fb_we, fb_addr, fb_h, fb_v, fb_data,
    input  ray_done, rtx_pixel
  );

  modport slave (
    input  new_ray, pixel_h_out, pixel_v_out,
    input  fb_we, fb_addr, fb_h, fb_v, fb_data,
    output ray_done, rtx_pixel
  );
endinterface

// File: rtl/rtx_pixel_scheduler_coord_fifo.sv
// rtx_coord_fifo: synchronous FIFO of issued coordinates, DEPTH a power of 2.
// Ports: clk, rst, push/din, pop/head, full, empty, count (= rays in flight).
module rtx_coord_fifo
  import rtx_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  coord_t                   din,
  input  logic                     pop,
  output coord_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  coord_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/rtx_pixel_scheduler.sv
// rtx_pixel_scheduler: raster-order ray issue with bounded in-flight count,
// in-order result pairing and one framebuffer write per pixel.
// Ports: clk, rst (sync, active high), start_frame, bus (master: new_ray,
// pixel_h_out/v_out, ray_done, rtx_pixel, fb_*), busy, frame_done,
// err_spurious. Macro RTX_SCHED_CONTINUOUS_EN: restart each frame on its own.
module rtx_pixel_scheduler
  import rtx_types::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int MAX_IN_FLIGHT = 8,
  parameter int ISSUE_GAP     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_frame,
  rtx_pixel_scheduler_if.master  bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_spurious
);
  localparam int AW = fb_addr_w(WIDTH, HEIGHT);
  localparam int CW = $clog2(MAX_IN_FLIGHT) + 1;
  localparam int GW = $clog2(ISSUE_GAP + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [H_W-1:0] H_LAST = H_W'(WIDTH - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(HEIGHT - 1);
  localparam logic [AW-1:0]  A_LAST = AW'(WIDTH * HEIGHT - 1);
  localparam logic [GW-1:0]  GAP    = GW'(ISSUE_GAP);

  logic [1:0]     state;
  logic [H_W-1:0] h_q;
  logic [V_W-1:0] v_q;
  logic [GW-1:0]  since_q;
  logic [AW-1:0]  wr_cnt;
  logic           issue;
  logic           accept;
  logic           restart;
  logic           take;
  logic           last_wr;
  coord_t         push_c;
  coord_t         head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  in_flight;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  coord_t         wc_q;
  logic [15:0]    data_q;

  assign push_c  = '{h: h_q, v: v_q};
  assign take    = bus.ray_done && !empty;
  assign issue   = (state == S_ISSUE)
                && (in_flight < CW'(MAX_IN_FLIGHT))
                && (since_q >= GAP);
  // frame_done still high means IDLE was entered this very cycle
  assign accept  = (state == S_IDLE) && start_frame && !frame_done;
  assign last_wr = take && (wr_cnt == A_LAST);
`ifdef RTX_SCHED_CONTINUOUS_EN
  assign restart = (state == S_IDLE) && frame_done;
`else
  assign restart = 1'b0;
`endif

  rtx_coord_fifo #(
    .DEPTH (MAX_IN_FLIGHT)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (push_c),
    .pop   (take),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (in_flight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      since_q <= '0;
      busy    <= 1'b0;
    end else if (accept || restart) begin
      state   <= S_ISSUE;
      h_q     <= '0;
      v_q     <= '0;
      since_q <= GAP;
      busy    <= 1'b1;
    end else begin
      if (issue) begin
        since_q <= GW'(1);
        if (h_q == H_LAST) begin
          h_q <= '0;
          if (v_q == V_LAST) state <= S_DRAIN;
          else               v_q   <= v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end else if (since_q < GAP) begin
        since_q <= since_q + 1'b1;
      end
      if (last_wr) begin
        state <= S_IDLE;
`ifndef RTX_SCHED_CONTINUOUS_EN
        busy  <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wc_q         <= '0;
      data_q       <= '0;
      wr_cnt       <= '0;
      frame_done   <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      we_q       <= take;
      frame_done <= last_wr;
      if (take) begin
        addr_q <= wr_cnt;
        wc_q   <= head;
        data_q <= bus.rtx_pixel;
        wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
      end
      if (accept) wr_cnt <= '0;
      if (bus.ray_done && empty) err_spurious <= 1'b1;
    end
  end

  assign bus.new_ray     = issue;
  assign bus.pixel_h_out = h_q;
  assign bus.pixel_v_out = v_q;
  assign bus.fb_we       = we_q;
  assign bus.fb_addr     = addr_q;
  assign bus.fb_h        = wc_q.h;
  assign bus.fb_v        = wc_q.v;
  assign bus.fb_data     = data_q;

  a_fb_addr: assert property (@(posedge clk) disable iff (rst)
    bus.fb_we |-> int'(bus.fb_addr) == int'(bus.fb_v) * WIDTH + int'(bus.fb_h));

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(issue && full));
endmodule

// File: tb/tb_rtx_pixel_scheduler.sv
// Bench for rtx_pixel_scheduler on a 4x2 frame with a queue-based tracer
// model; expected writes and issue times derive from the frame rules.
module tb_rtx_pixel_scheduler;
  import rtx_types::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int MIF  = 2;
  localparam int GAP  = 3;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(W * H);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_frame = 1'b0;
  logic busy;
  logic frame_done;
  logic err_spurious;

  rtx_pixel_scheduler_if #(.AW(AW)) bus ();

  rtx_pixel_scheduler #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .MAX_IN_FLIGHT (MIF),
    .ISSUE_GAP     (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_frame  (start_frame),
    .bus          (bus),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat_min = 5;
  int lat_max = 5;
  bit rand_data  = 1'b0;
  bit extra_done = 1'b0;
  int last_done  = 0;

  int          pend[$];
  int          iss_t[$];
  int          iss_h[$];
  int          iss_v[$];
  int          done_t[$];
  logic [15:0] sent[$];
  int          wr_t[$];
  int          wr_a[$];
  int          wr_h[$];
  int          wr_v[$];
  logic [15:0] wr_d[$];
  bit          wr_fd[$];
  int          fd_t[$];

  task automatic clear_model();
    pend.delete();   iss_t.delete(); iss_h.delete(); iss_v.delete();
    done_t.delete(); sent.delete();  wr_t.delete();  wr_a.delete();
    wr_h.delete();   wr_v.delete();  wr_d.delete();  wr_fd.delete();
    fd_t.delete();
    last_done  = 0;
    extra_done = 1'b0;
  endtask

  // one cycle: observe outputs, then drive the in-order tracer model
  task automatic tick();
    int dt;
    @(negedge clk);
    cyc++;
    if (bus.new_ray === 1'b1) begin
      iss_t.push_back(cyc);
      iss_h.push_back(int'(bus.pixel_h_out));
      iss_v.push_back(int'(bus.pixel_v_out));
      dt = cyc + int'($urandom_range(lat_max, lat_min));
      if (dt <= last_done) dt = last_done + 1;
      last_done = dt;
      pend.push_back(dt);
    end
    if (bus.fb_we === 1'b1) begin
      wr_t.push_back(cyc);
      wr_a.push_back(int'(bus.fb_addr));
      wr_h.push_back(int'(bus.fb_h));
      wr_v.push_back(int'(bus.fb_v));
      wr_d.push_back(bus.fb_data);
      wr_fd.push_back(frame_done);
    end
    if (frame_done === 1'b1) fd_t.push_back(cyc);
    bus.ray_done = 1'b0;
    if (pend.size() > 0 && pend[0] == cyc) begin
      void'(pend.pop_front());
      bus.ray_done  = 1'b1;
      bus.rtx_pixel = rand_data ? 16'($urandom)
                                : 16'h1000 + 16'(done_t.size());
      done_t.push_back(cyc);
      sent.push_back(bus.rtx_pixel);
    end else if (extra_done) begin
      bus.ray_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_frame = 1'b0;
    bus.ray_done = 1'b0;
    clear_model();
    tick();
    rst = 1'b0;
  endtask

  task automatic start(output int s0);
    s0 = cyc;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic run_frame(input int budget, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (fd_t.size() == 0) begin
      if (n == budget) begin
        to = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  function automatic int exp_issue(input int j, input int s0);
    int e;
    if (j == 0) return s0 + 1;
    e = iss_t[j-1] + GAP;
    if (j >= MIF && done_t[j-MIF] + 1 > e) e = done_t[j-MIF] + 1;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    n_tests++;
    if ({bus.new_ray, bus.pixel_h_out, bus.pixel_v_out, bus.fb_we,
         bus.fb_addr, bus.fb_h, bus.fb_v, bus.fb_data, busy,
         frame_done, err_spurious} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: not all zero"); end
    rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.new_ray !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: new_ray=%b busy=%b want 0 0",
               bus.new_ray, busy);
    end
  endtask

  task automatic test_frame_fixed();
    int s0;
    bit to;
    do_reset();
    lat_min = 5; lat_max = 5; rand_data = 1'b0;
    start(s0);
    run_frame(300, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL frame_timeout: no frame_done"); end
    n_tests++;
    if (wr_t.size() != NPIX || iss_t.size() != NPIX) begin
      n_fail++;
      $display("FAIL frame_counts: writes=%0d issues=%0d want %0d",
               wr_t.size(), iss_t.size(), NPIX);
    end
    n_tests++;
    if (iss_t.size() == 0 || iss_t[0] != s0 + 1) begin
      n_fail++;
      $display("FAIL first_issue: got cycle %0d want %0d",
               iss_t.size() ? iss_t[0] : -1, s0 + 1);
    end
    for (int k = 0; k < NPIX && k < wr_t.size(); k++) begin
      n_tests++;
      if (wr_a[k] != k || wr_h[k] != k % W || wr_v[k] != k / W ||
          wr_d[k] !== 16'h1000 + 16'(k) || wr_t[k] != done_t[k] + 1) begin
        n_fail++;
        $display("FAIL write_%0d: a=%0d h=%0d v=%0d d=%h t=%0d want %0d %0d %0d %h %0d",
                 k, wr_a[k], wr_h[k], wr_v[k], wr_d[k], wr_t[k],
                 k, k % W, k / W, 16'h1000 + 16'(k), done_t[k] + 1);
      end
    end
    for (int k = 0; k < NPIX && k < iss_t.size(); k++) begin
      n_tests++;
      if (iss_h[k] != k % W || iss_v[k] != k / W) begin
        n_fail++;
        $display("FAIL issue_coord_%0d: (%0d,%0d) want (%0d,%0d)",
                 k, iss_h[k], iss_v[k], k % W, k / W);
      end
    end
    n_tests++;
    if (fd_t.size() != 1 || wr_t.size() != NPIX ||
        fd_t[0] != wr_t[NPIX-1] || wr_fd[NPIX-1] != 1'b1) begin
      n_fail++;
      $display("FAIL frame_done_timing: fd_count=%0d want with last write",
               fd_t.size());
    end
`ifdef RTX_SCHED_CONTINUOUS_EN
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_cont: got %b want 1", busy);
    end
    tick();
    n_tests++;
    if (iss_t.size() != NPIX + 1 || iss_t[NPIX] != fd_t[0] + 1) begin
      n_fail++;
      $display("FAIL cont_restart: issues=%0d want next new_ray at %0d",
               iss_t.size(), fd_t[0] + 1);
    end
`else
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_drop: got %b want 0", busy);
    end
    repeat (10) tick();
    n_tests++;
    if (iss_t.size() != NPIX || wr_t.size() != NPIX) begin
      n_fail++;
      $display("FAIL idle_after_frame: issues=%0d writes=%0d want %0d",
               iss_t.size(), wr_t.size(), NPIX);
    end
`endif
  endtask

  task automatic test_backpressure();
    int s0;
    bit to;
    int worst;
    int out;
    int bad;
    do_reset();
    lat_min = 20; lat_max = 20; rand_data = 1'b1;
    start(s0);
    run_frame(800, to);
    n_tests++;
    if (to || wr_t.size() != NPIX) begin
      n_fail++;
      $display("FAIL bp_writes: got %0d want %0d (timeout=%0d)",
               wr_t.size(), NPIX, to);
    end
    worst = 0;
    bad = -1;
    for (int j = 0; j < iss_t.size(); j++) begin
      out = j + 1;
      foreach (done_t[d]) if (done_t[d] < iss_t[j]) out--;
      if (out > worst) worst = out;
      if (bad < 0 && iss_t[j] != exp_issue(j, s0)) bad = j;
    end
    n_tests++;
    if (worst > MIF || worst < MIF) begin
      n_fail++;
      $display("FAIL bp_in_flight: peak %0d want %0d", worst, MIF);
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL bp_issue_time: issue %0d at %0d want %0d",
               bad, iss_t[bad], exp_issue(bad, s0));
    end
  endtask

  task automatic test_gap();
    int s0;
    bit to;
    do_reset();
    lat_min = 1; lat_max = 1; rand_data = 1'b1;
    start(s0);
    run_frame(300, to);
    n_tests++;
    if (to || iss_t.size() != NPIX || wr_t.size() != NPIX) begin
      n_fail++;
      $display("FAIL gap_counts: issues=%0d writes=%0d want %0d",
               iss_t.size(), wr_t.size(), NPIX);
    end
    for (int j = 1; j < iss_t.size(); j++) begin
      n_tests++;
      if (iss_t[j] - iss_t[j-1] != GAP) begin
        n_fail++;
        $display("FAIL gap_%0d: spacing %0d want %0d",
                 j, iss_t[j] - iss_t[j-1], GAP);
      end
    end
  endtask

  task automatic test_random();
    int s0;
    bit to;
    int bad;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      lat_min = 1;
      lat_max = int'($urandom_range(15, 1));
      rand_data = 1'b1;
      start(s0);
      run_frame(1000, to);
      n_tests++;
      if (to || wr_t.size() != NPIX || fd_t.size() != 1) begin
        n_fail++;
        $display("FAIL rand%0d_counts: writes=%0d fd=%0d want %0d 1",
                 it, wr_t.size(), fd_t.size(), NPIX);
      end
      bad = -1;
      for (int k = 0; k < wr_t.size() && k < NPIX; k++)
        if (bad < 0 && (wr_a[k] != k || wr_h[k] != k % W ||
            wr_v[k] != k / W || wr_d[k] !== sent[k] ||
            wr_t[k] != done_t[k] + 1)) bad = k;
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL rand%0d_write_%0d: a=%0d d=%h t=%0d want %0d %h %0d",
                 it, bad, wr_a[bad], wr_d[bad], wr_t[bad],
                 bad, sent[bad], done_t[bad] + 1);
      end
      bad = -1;
      for (int j = 0; j < iss_t.size(); j++)
        if (bad < 0 && iss_t[j] != exp_issue(j, s0)) bad = j;
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL rand%0d_issue_%0d: at %0d want %0d",
                 it, bad, iss_t[bad], exp_issue(bad, s0));
      end
    end
  endtask

  task automatic test_spurious();
    int s0;
    bit to;
    do_reset();
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    tick();
    n_tests++;
    if (bus.fb_we !== 1'b0 || err_spurious !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_flag: fb_we=%b err=%b want 0 1",
               bus.fb_we, err_spurious);
    end
    repeat (5) tick();
    n_tests++;
    if (err_spurious !== 1'b1 || wr_t.size() != 0) begin
      n_fail++;
      $display("FAIL spurious_sticky: err=%b writes=%0d want 1 0",
               err_spurious, wr_t.size());
    end
    lat_min = 2; lat_max = 6; rand_data = 1'b1;
    start(s0);
    run_frame(400, to);
    n_tests++;
    if (to || wr_t.size() != NPIX || err_spurious !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_frame: writes=%0d err=%b want %0d 1",
               wr_t.size(), err_spurious, NPIX);
    end
    do_reset();
    n_tests++;
    if (err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL spurious_clear: got %b want 0", err_spurious);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    int n;
    bit to;
    do_reset();
    lat_min = 5; lat_max = 5; rand_data = 1'b0;
    start(s0);
    n = 0;
    while (iss_t.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    n_tests++;
    if (iss_t.size() != 3) begin
      n_fail++; $display("FAIL mid_three_issues: got %0d want 3", iss_t.size());
    end
    rst = 1'b1;
    clear_model();
    bus.ray_done = 1'b0;
    tick();
    n_tests++;
    if ({bus.new_ray, bus.pixel_h_out, bus.pixel_v_out, bus.fb_we,
         bus.fb_addr, bus.fb_h, bus.fb_v, bus.fb_data, busy,
         frame_done, err_spurious} !== '0)
      begin n_fail++; $display("FAIL mid_reset_outputs: not all zero"); end
    rst = 1'b0;
    tick();
    start(s0);
    run_frame(300, to);
    n_tests++;
    if (to || iss_t.size() != NPIX || iss_t[0] != s0 + 1 ||
        iss_h[0] != 0 || iss_v[0] != 0) begin
      n_fail++;
      $display("FAIL mid_restart_issue: issues=%0d first=(%0d,%0d)@%0d want (0,0)@%0d",
               iss_t.size(), iss_h[0], iss_v[0], iss_t[0], s0 + 1);
    end
    n_tests++;
    if (wr_t.size() != NPIX || wr_a[0] != 0 || wr_a[NPIX-1] != NPIX - 1) begin
      n_fail++;
      $display("FAIL mid_restart_writes: n=%0d first=%0d want %0d 0",
               wr_t.size(), wr_a[0], NPIX);
    end
  endtask

  task automatic test_start_ignored();
    int s0;
    int f;
    bit to;
    do_reset();
    lat_min = 4; lat_max = 4; rand_data = 1'b0;
    start(s0);
    repeat (6) tick();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    run_frame(300, to);
    n_tests++;
    if (to || wr_t.size() != NPIX || fd_t.size() != 1 ||
        iss_t.size() != NPIX || wr_a[NPIX-1] != NPIX - 1) begin
      n_fail++;
      $display("FAIL start_mid_ignored: writes=%0d fd=%0d issues=%0d want %0d",
               wr_t.size(), fd_t.size(), iss_t.size(), NPIX);
    end
`ifndef RTX_SCHED_CONTINUOUS_EN
    f = cyc;
    start_frame = 1'b1;
    tick();
    n_tests++;
    if (iss_t.size() != NPIX || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_fd_cycle: issues=%0d busy=%b want %0d 0",
               iss_t.size(), busy, NPIX);
    end
    tick();
    start_frame = 1'b0;
    n_tests++;
    if (iss_t.size() != NPIX + 1 || iss_t[NPIX] != f + 2 ||
        iss_h[NPIX] != 0 || iss_v[NPIX] != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_after_fd: issues=%0d busy=%b want new_ray at %0d",
               iss_t.size(), busy, f + 2);
    end
`else
    f = cyc;
    tick();
    n_tests++;
    if (iss_t.size() != NPIX + 1 || iss_t[NPIX] != f + 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_next_frame: issues=%0d busy=%b want new_ray at %0d",
               iss_t.size(), busy, f + 1);
    end
`endif
    do_reset();
  endtask

  initial begin
    bus.ray_done  = 1'b0;
    bus.rtx_pixel = 16'h0;
    test_reset();
    test_frame_fixed();
    test_backpressure();
    test_gap();
    test_random();
    test_spurious();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rtx_pixel_scheduler.md
Name: rtx_pixel_scheduler

Overview:
- Drives the ray-tracing core (ray maker followed by ray tracer) for a whole frame.
- Walks pixels in raster order and issues new_ray with pixel_h/pixel_v.
- Bounds the number of rays in flight and keeps a FIFO of issued coordinates.
- Pairs each ray_done/rtx_pixel result with its coordinate and emits one framebuffer write per pixel, then a frame_done pulse.

Parameters:
- WIDTH, 1280, pixels per line.
- HEIGHT, 720, lines per frame.
- MAX_IN_FLIGHT, 8, max issued-but-unfinished rays; also the FIFO depth; power of two, ≥2.
- ISSUE_GAP, 1, minimum cycles between consecutive new_ray pulses (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_frame  in  1  pulse; begins a frame when idle
- ray_done  in  1  one result valid this cycle
- rtx_pixel  in  16  RGB565 result accompanying ray_done
- new_ray  out  1  single-cycle issue strobe to the ray maker
- pixel_h_out  out  11  issued pixel column, valid with new_ray
- pixel_v_out  out  10  issued pixel row, valid with new_ray
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  $clog2(WIDTH*HEIGHT)  write address, equal to v*WIDTH+h
- fb_h  out  11  write column
- fb_v  out  10  write row
- fb_data  out  16  RGB565 pixel
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  single-cycle pulse
- err_spurious  out  1  sticky; ray_done arrived with nothing in flight

Behaviour:
- Reset: all outputs 0; state IDLE; counters, FIFO and err_spurious cleared. Reset mid-frame abandons the frame with no further writes; the tracer shares the same rst.
- Result ordering: the tracer returns results in issue order, so FIFO order defines pairing.
- IDLE:
  - start_frame → ISSUE next cycle; h=v=0, write address counter=0, busy=1.
  - start_frame while not IDLE is ignored.
- ISSUE:
  - new_ray pulses in a cycle when in_flight<MAX_IN_FLIGHT and ≥ISSUE_GAP cycles have passed since the previous pulse.
  - The first pulse occurs the cycle after start_frame.
  - The issued (h,v) is pushed to the FIFO the same cycle.
  - h increments; at WIDTH-1, h wraps to 0 and v increments.
  - After issuing (WIDTH-1,HEIGHT-1) → DRAIN.
- DRAIN: no issues. When the final write has been emitted → IDLE.
- in_flight:
  - +1 on issue, −1 on ray_done; unchanged when both happen in the same cycle.
  - Never exceeds MAX_IN_FLIGHT. The FIFO is never pushed when full.
- Write path:
  - ray_done at cycle t → fb_we=1 at t+1, with fb_data=rtx_pixel sampled at t, fb_h/fb_v=FIFO head, fb_addr=running counter.
  - The counter increments after each write.
  - Back-to-back ray_done gives back-to-back writes.
- ray_done when in_flight==0 (including in IDLE): ignored, no write, err_spurious set until reset.
- frame_done: asserted in the same cycle as the write of pixel (WIDTH-1,HEIGHT-1); busy drops that same cycle.
- A start_frame in the frame_done cycle is ignored; a start_frame one cycle later is accepted.
- Width rules: fb_addr computed by counter, never by multiply. An internal assertion checks fb_addr==fb_v*WIDTH+fb_h.

Optional Feature:
- Macro RTX_SCHED_CONTINUOUS_EN.
- Defined: on frame_done, the scheduler re-enters ISSUE for the next frame without start_frame. busy stays 1 and the first new_ray of the next frame comes the cycle after frame_done. start_frame only leaves IDLE after reset.
- Undefined: returns to IDLE and waits for start_frame.

Decomposition:
- Shared package (rtx_types): FB_ADDR_W derived from WIDTH*HEIGHT, plus the packed coord typedef {h[10:0], v[9:0]}.
- One sub-module, rtx_coord_fifo: synchronous FIFO of coords, depth MAX_IN_FLIGHT, with push, pop, full, empty and count. count serves as in_flight.

Test Plan:
- WIDTH=4, HEIGHT=2, tracer model with fixed 5-cycle latency returning rtx_pixel=16'h1000+addr → exactly 8 writes, fb_addr 0..7 in order, fb_data 16'h1000..16'h1007, (fb_h,fb_v) consistent, frame_done with write 7.
- MAX_IN_FLIGHT=2, tracer latency 20 → never more than 2 outstanding new_ray; issue resumes the cycle after each ray_done; total writes = 8.
- ISSUE_GAP=3, instant tracer → new_ray pulses exactly 3 cycles apart.
- Spurious ray_done in IDLE → no fb_we, err_spurious=1 and it stays 1.
- Reset asserted after 3 issues → all outputs 0 next cycle. A following start_frame restarts at (0,0) with fb_addr 0.
- start_frame mid-frame → ignored; frame still completes with exactly 8 writes. With RTX_SCHED_CONTINUOUS_EN → the second frame's first new_ray comes one cycle after frame_done.
